tnn_layer_seq: RTL and testbench

TNN_LAYER_SEQ -- requirements
Module: tnn_layer_seq

---
 rtl/tnn_seq_pkg.sv | 24 ++
 rtl/tnn_layer_seq.sv | 145 ++++++++++++++
 tb/tb_tnn_layer_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tnn_seq_pkg.sv
// Shared types and helpers for the time-multiplexed ternary-neuron layer sequencer.
// Holds the feature geometry, the sequencer state encoding and the popcount used for out_count.
package tnn_seq_pkg;

    localparam int FEAT_W_DEF  = 3;
    localparam int NUM_FEAT    = 5;
    localparam int MAX_NEURONS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [4:0] popcount16(input logic [MAX_NEURONS-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_NEURONS; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/tnn_layer_seq.sv
// Sequences one feature vector through NUM_NEURONS masked evaluations of an external
// combinational neuron core, one neuron per clock, and presents the decision bits plus their count.
module tnn_layer_seq
    import tnn_seq_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int FEAT_W      = FEAT_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_FEAT*FEAT_W-1:0]         in_feat,
    input  logic                               cfg_we,
    input  logic [$clog2(NUM_NEURONS)-1:0]     cfg_addr,
    input  logic [NUM_FEAT*FEAT_W-1:0]         cfg_mask,
    output logic                               cfg_ready,
    output logic [FEAT_W-1:0]                  core_a,
    output logic [FEAT_W-1:0]                  core_b,
    output logic [FEAT_W-1:0]                  core_c,
    output logic [FEAT_W-1:0]                  core_d,
    output logic [FEAT_W-1:0]                  core_e,
    input  logic                               core_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_NEURONS-1:0]             out_bits,
    output logic [$clog2(NUM_NEURONS+1)-1:0]   out_count
);

    localparam int VEC_W = NUM_FEAT * FEAT_W;
    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam int CNT_W = $clog2(NUM_NEURONS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [VEC_W-1:0]       feat_q, feat_d;
    logic [NUM_NEURONS-1:0] out_bits_q, out_bits_d;
    logic [CNT_W-1:0]       out_count_q, out_count_d;

    logic [VEC_W-1:0]       mask_all [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] bits_upd;
    logic [VEC_W-1:0]       core_vec;
    logic                   cfg_wr;

    // Out-of-range addresses never match a neuron, so they are dropped without side effect.
    assign cfg_wr = cfg_we && cfg_ready && (CNT_W'(cfg_addr) < CNT_W'(NUM_NEURONS));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_mask
            logic [VEC_W-1:0] mask_q, mask_d;

            always_comb begin
                mask_d = mask_q;
                if (cfg_wr && (cfg_addr == IDX_W'(gi))) begin
                    mask_d = cfg_mask;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mask_q <= '0;
                end else begin
                    mask_q <= mask_d;
                end
            end

            assign mask_all[gi] = mask_q;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        feat_d      = feat_q;
        out_bits_d  = out_bits_q;
        out_count_d = out_count_q;
        bits_upd    = out_bits_q;
        core_vec    = '0;
        in_ready    = 1'b0;
        cfg_ready   = 1'b0;
        out_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                if (in_valid) begin
                    feat_d      = in_feat;
                    out_bits_d  = '0;
                    out_count_d = '0;
                    idx_d       = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                // A mask written on the acceptance edge is already in mask_all here.
                core_vec        = feat_q ^ mask_all[idx_q];
                bits_upd[idx_q] = core_out;
                out_bits_d      = bits_upd;
                if (idx_q == LAST_IDX) begin
                    out_count_d = CNT_W'(popcount16(MAX_NEURONS'(bits_upd)));
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            feat_q      <= '0;
            out_bits_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            feat_q      <= feat_d;
            out_bits_q  <= out_bits_d;
            out_count_q <= out_count_d;
        end
    end

    assign core_a    = core_vec[0*FEAT_W +: FEAT_W];
    assign core_b    = core_vec[1*FEAT_W +: FEAT_W];
    assign core_c    = core_vec[2*FEAT_W +: FEAT_W];
    assign core_d    = core_vec[3*FEAT_W +: FEAT_W];
    assign core_e    = core_vec[4*FEAT_W +: FEAT_W];
    assign out_bits  = out_bits_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_tnn_layer_seq.sv
// Scoreboard bench for tnn_layer_seq: a behavioural neuron-layer model predicts each result,
// a negedge monitor checks every presented output, latency and DONE stability.
module tb_tnn_layer_seq;

    localparam int N  = 8;
    localparam int FW = 3;
    localparam int VW = 5 * FW;
    localparam int N6 = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT (8 neurons)
    logic          in_valid, in_ready, cfg_we, cfg_ready, core_out, out_valid, out_ready;
    logic [VW-1:0] in_feat, cfg_mask;
    logic [2:0]    cfg_addr;
    logic [FW-1:0] core_a, core_b, core_c, core_d, core_e;
    logic [N-1:0]  out_bits;
    logic [3:0]    out_count;

    // second DUT (6 neurons) for out-of-range configuration addresses
    logic          in6_valid, in6_ready, cfg6_we, cfg6_ready, core6_out, out6_valid, out6_ready;
    logic [VW-1:0] in6_feat, cfg6_mask;
    logic [2:0]    cfg6_addr;
    logic [FW-1:0] core6_a, core6_b, core6_c, core6_d, core6_e;
    logic [N6-1:0] out6_bits;
    logic [2:0]    out6_count;

    tnn_layer_seq #(.NUM_NEURONS(N), .FEAT_W(FW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_ready(cfg_ready),
        .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d), .core_e(core_e),
        .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_count(out_count)
    );

    tnn_layer_seq #(.NUM_NEURONS(N6), .FEAT_W(FW)) dut6 (
        .clk(clk), .rst(rst),
        .in_valid(in6_valid), .in_ready(in6_ready), .in_feat(in6_feat),
        .cfg_we(cfg6_we), .cfg_addr(cfg6_addr), .cfg_mask(cfg6_mask), .cfg_ready(cfg6_ready),
        .core_a(core6_a), .core_b(core6_b), .core_c(core6_c), .core_d(core6_d), .core_e(core6_e),
        .core_out(core6_out),
        .out_valid(out6_valid), .out_ready(out6_ready), .out_bits(out6_bits), .out_count(out6_count)
    );

    // Neuron core models: 0 = AND of all bits, 1 = (a == 0), 2 = parity.
    int mode = 0;

    function automatic logic core_fn(input int m, input logic [VW-1:0] v);
        case (m)
            0:       return &v;
            1:       return (v[FW-1:0] == '0);
            default: return ^v;
        endcase
    endfunction

    assign core_out  = core_fn(mode, {core_e, core_d, core_c, core_b, core_a});
    assign core6_out = core_fn(0, {core6_e, core6_d, core6_c, core6_b, core6_a});

    // Reference model state and scoreboard
    typedef struct {
        logic [N-1:0] bits;
        int           cnt;
        int unsigned  acc;
    } exp_t;

    logic [VW-1:0] mask_m [N];
    exp_t          q[$];
    exp_t          mon_e;
    int            n_chk  = 0;
    int            n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: checks each presented result against the scoreboard head.
    logic         prev_v  = 1'b0;
    logic         prev_hs = 1'b0;
    logic [N-1:0] prev_bits;
    logic [3:0]   prev_cnt;

    always @(negedge clk) begin
        if (rst) begin
            prev_v  <= 1'b0;
            prev_hs <= 1'b0;
        end else begin
            if (out_valid) begin
                chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
                if (!prev_v || prev_hs) begin
                    if (q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
                    else chk("latency_edges", cyc + 1 - q[0].acc, 32'(N + 1));
                end else begin
                    chk("out_bits_stable", 32'(out_bits), 32'(prev_bits));
                    chk("out_count_stable", 32'(out_count), 32'(prev_cnt));
                end
                if (out_ready && q.size() > 0) begin
                    mon_e = q.pop_front();
                    $display("result bits=%02h count=%0d exp_bits=%02h exp_count=%0d",
                             out_bits, out_count, mon_e.bits, mon_e.cnt);
                    chk("out_bits", 32'(out_bits), 32'(mon_e.bits));
                    chk("out_count", 32'(out_count), 32'(mon_e.cnt));
                end
            end
            prev_v    <= out_valid;
            prev_hs   <= out_valid && out_ready;
            prev_bits <= out_bits;
            prev_cnt  <= out_count;
        end
    end

    // Called at posedge+1 while idle; optional same-edge mask write.
    task automatic issue(input logic [VW-1:0] feat, input bit do_cfg,
                         input logic [2:0] addr, input logic [VW-1:0] m);
        exp_t e;
        int   c;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        if (do_cfg) begin
            cfg_we   = 1'b1;
            cfg_addr = addr;
            cfg_mask = m;
            mask_m[addr] = m;
        end
        in_valid = 1'b1;
        in_feat  = feat;
        c = 0;
        e.bits = '0;
        for (int i = 0; i < N; i++) begin
            e.bits[i] = core_fn(mode, feat ^ mask_m[i]);
            c += int'(e.bits[i]);
        end
        e.cnt = c;
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic cfg_wr(input logic [2:0] addr, input logic [VW-1:0] m);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_mask = m;
        mask_m[addr] = m;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Waits until the scoreboard is empty; optionally random backpressure and dropped cfg writes.
    task automatic wait_drain(input bit rnd);
        int k;
        k = 0;
        while (q.size() > 0 && k < 300) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            chk("cfg_ready_busy", 32'(cfg_ready), 32'd0);
            if (rnd) begin
                out_ready = 1'($urandom_range(0, 1));
                cfg_we    = 1'($urandom_range(0, 1));
                cfg_addr  = 3'($urandom_range(0, 7));
                cfg_mask  = 15'($urandom);
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        if (q.size() > 0) begin
            chk("drain_timeout", 32'd0, 32'd1);
            q.delete();
        end
    endtask

    initial begin
        int          k;
        int unsigned a6;

        rst = 1'b1;
        in_valid = 0; in_feat = '0; cfg_we = 0; cfg_addr = '0; cfg_mask = '0; out_ready = 1'b1;
        in6_valid = 0; in6_feat = '0; cfg6_we = 0; cfg6_addr = '0; cfg6_mask = '0; out6_ready = 1'b1;
        for (int i = 0; i < N; i++) mask_m[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bits", 32'(out_bits), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_core_idle", 32'({core_e, core_d, core_c, core_b, core_a}), 32'd0);

        // Nonzero masks everywhere, parity core
        mode = 2;
        for (int i = 0; i < N; i++) cfg_wr(3'(i), 15'($urandom) | 15'h0001);
        issue(15'($urandom), 1'b0, 3'd0, '0);
        wait_drain(1'b0);

        // Reset mid-RUN abandons the inference and clears masks
        mode = 0;
        issue(15'h7FFF, 1'b0, 3'd0, '0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        q.delete();
        #1 chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) mask_m[i] = '0;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        repeat (12) begin @(posedge clk); #1; end

        // Passthrough with zero masks: expect FF / 8
        issue(15'h7FFF, 1'b0, 3'd0, '0);
        wait_drain(1'b0);

        // Masking: neuron 3 flips feature a to zero: expect 08 / 1
        mode = 1;
        cfg_wr(3'd3, 15'h0007);
        issue({12'($urandom), 3'd7}, 1'b0, 3'd0, '0);
        wait_drain(1'b0);

        // Backpressure: DONE held with stable outputs, in_valid ignored
        mode = 2;
        issue(15'($urandom), 1'b0, 3'd0, '0);
        out_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
        chk("bp_reached_done", 32'(out_valid), 32'd1);
        repeat (5) begin
            in_valid = 1'b1;
            in_feat  = 15'($urandom);
            @(posedge clk); #1;
            chk("bp_valid_held", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released_out_valid", 32'(out_valid), 32'd0);
        chk("bp_released_in_ready", 32'(in_ready), 32'd1);
        if (q.size() > 0) begin chk("bp_result_consumed", 32'd0, 32'd1); q.delete(); end

        // Config gating: write during RUN dropped; same-edge write applies to that inference
        mode = 0;
        issue(15'h7FFF, 1'b0, 3'd0, '0);
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_mask = 15'h7FFF;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        wait_drain(1'b0);
        issue(15'h7FFF, 1'b1, 3'd5, 15'h0100);
        wait_drain(1'b0);

        // Out-of-range cfg addresses on the 6-neuron instance
        cfg6_we = 1'b1; cfg6_addr = 3'd6; cfg6_mask = 15'h7FFF;
        @(posedge clk); #1;
        cfg6_addr = 3'd7;
        @(posedge clk); #1;
        cfg6_addr = 3'd5; cfg6_mask = 15'h0001;
        @(posedge clk); #1;
        cfg6_we = 1'b0;
        chk("n6_in_ready", 32'(in6_ready), 32'd1);
        in6_valid = 1'b1; in6_feat = 15'h7FFF;
        a6 = cyc + 1;
        @(posedge clk); #1;
        in6_valid = 1'b0;
        k = 0;
        while (!out6_valid && k < 40) begin @(posedge clk); #1; k++; end
        $display("n6 result bits=%02h count=%0d", out6_bits, out6_count);
        chk("n6_latency", cyc - a6, 32'(N6));
        chk("n6_out_bits", 32'(out6_bits), 32'h1F);
        chk("n6_out_count", 32'(out6_count), 32'd5);
        @(posedge clk); #1;
        chk("n6_out_valid_cleared", 32'(out6_valid), 32'd0);

        // Randomized inferences
        for (int t = 0; t < 20; t++) begin
            mode = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) cfg_wr(3'($urandom_range(0, 7)), 15'($urandom));
            issue(15'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 15'($urandom));
            wait_drain(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
